sm_target_packer: RTL and testbench
===================================

Name: sm_target_packer

Overview:
- Writer side of the scoring feeder's load interface (ld / feed_in / full).
- Accepts a host-side stream of 2-bit bases, one per beat, with a per-sequence ID and a last flag.
- Packs each sequence into the feeder's word format {ID, LENGTH, TARGET} and issues a one-cycle ld when the feeder reports not full.
- Sits between the host DMA/stream adapter and the feeder.

Parameters:
- TARGET_LENGTH, 128: maximum bases per sequence; TARGET field is 2*TARGET_LENGTH bits.
- LEN_WIDTH, 12: LENGTH field width; must satisfy 2^LEN_WIDTH > TARGET_LENGTH.
- ID_WIDTH, 48: ID field width.
- OUT_WIDTH, ID_WIDTH+LEN_WIDTH+2*TARGET_LENGTH: packed word width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- s_valid  in  1  input beat valid
- s_ready  out  1  packer can accept a beat
- s_base  in  2  base code for this beat
- s_last  in  1  this beat is the final base of the sequence
- s_id  in  ID_WIDTH  sequence ID, sampled on the first beat only
- full  in  1  feeder full flag; sole flow control for ld
- ld  out  1  one-cycle load strobe to the feeder
- feed_out  out  OUT_WIDTH  packed word: [OUT_WIDTH-1 -: ID_WIDTH]=ID, [2*TARGET_LENGTH+LEN_WIDTH-1 -: LEN_WIDTH]=LENGTH, [2*TARGET_LENGTH-1:0]=TARGET
- err_overflow  out  1  sticky: a sequence exceeded TARGET_LENGTH bases
- seq_count  out  16  number of ld pulses issued since reset; wraps at 2^16

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; ld=0; feed_out=0; err_overflow=0; seq_count=0; base counter=0.
  - s_ready is combinationally forced to 0 while rst=0.
  - A partially collected sequence is discarded; no ld is issued for it.
- Beat acceptance: a beat is accepted only at an edge where s_valid & s_ready.
- s_ready=1 in IDLE and COLLECT; s_ready=0 in HOLD and ISSUE.
- Packing order matches the feeder's right-shift output:
  - base k (0-based) goes to TARGET[2k+1:2k], so base 0 lands in TARGET[1:0] and is fed first.
  - TARGET bits above the last base are 0; TARGET is cleared at the start of each sequence.
  - LENGTH is the number of stored bases, zero-extended.
- State machine (state register of 2 bits):
  - IDLE: on an accepted beat, latch s_id, clear TARGET, store the base at index 0, set count=1.
    - If s_last on that beat, go to HOLD; otherwise go to COLLECT.
  - COLLECT: on an accepted beat, store the base at index count while count<TARGET_LENGTH, then count+1.
    - At count==TARGET_LENGTH, drop further beats (still accepted, s_ready stays 1), hold count, set err_overflow.
    - s_last goes to HOLD.
  - HOLD: feed_out stable. If full==0 at the edge, go to ISSUE with ld<=1; otherwise remain.
  - ISSUE: ld==1 for exactly this cycle with feed_out valid.
    - At the next edge: ld<=0, seq_count+1, go to IDLE.
- ld is a registered output; no combinational path from full to ld.
  - The feeder's full depends combinationally on ld, so full is only evaluated in HOLD, where ld=0.
  - This guarantees no loop and at least one idle cycle between ld pulses.
- Latency, no back-pressure:
  - last beat accepted at edge N: HOLD during cycle N..N+1, ld=1 during cycle N+1..N+2.
  - s_ready returns to 1 the cycle after ld falls.
- Gaps: s_valid=0 cycles in COLLECT change nothing; there is no timeout.
- err_overflow clears only on reset. The truncated sequence is still issued with LENGTH=TARGET_LENGTH.
- Beats with s_valid=1 while s_ready=0 are not consumed; the source must hold them.
- full rising while ld=1: the load is committed; the packer does not retry.

Decomposition:
- Shared package sm_pkg holds:
  - TARGET_LENGTH, LEN_WIDTH, ID_WIDTH defaults;
  - field offset localparams for ID/LENGTH/TARGET (shared with the feeder);
  - packer state encodings IDLE=0, COLLECT=1, HOLD=2, ISSUE=3.
- Single module; no sub-module. The base-insert write decoder is inline.

Test Plan:
- id=48'hABCDEF012345, bases 1,2,3,0 (last on 4th), full=0 -> one ld pulse 2 cycles after the last beat; ID=ABCDEF012345, LENGTH=4, TARGET[7:0]=8'h39, TARGET[255:8]=0; seq_count=1.
- Same sequence with full=1 for 10 cycles after entering HOLD -> ld=0, s_ready=0, feed_out constant; full->0 -> ld=1 exactly one cycle later, lasting one cycle.
- 130 bases, all 2'b11, last on 130th -> LENGTH=128, TARGET=all ones, err_overflow=1 and stays 1 through the next normal sequence.
- Single beat with s_last=1, base=2, id=5 -> LENGTH=1, TARGET=2; back-to-back second sequence packs with TARGET cleared (no leftover bits).
- Random s_valid gaps (50% duty) over 37 bases -> bit-exact packing vs. model, LENGTH=37.
- rst=0 for one cycle after 5 collected bases -> no ld; err_overflow=0, seq_count=0; a following 3-base sequence yields LENGTH=3 with a clean TARGET.

Source files
------------

// File: rtl/sm_target_packer_pkg.sv
// Shared definitions for the scoring feeder load path.
// Holds default field widths, the packed-word field offsets that the feeder
// also uses, and the packer state encoding.
package sm_target_packer_pkg;

    localparam int unsigned DEF_TARGET_LENGTH = 128;
    localparam int unsigned DEF_LEN_WIDTH     = 12;
    localparam int unsigned DEF_ID_WIDTH      = 48;
    localparam int unsigned DEF_OUT_WIDTH     = DEF_ID_WIDTH + DEF_LEN_WIDTH + 2 * DEF_TARGET_LENGTH;

    // Feeder word layout: {ID, LENGTH, TARGET}, TARGET at the bottom.
    localparam int unsigned DEF_TARGET_LSB = 0;
    localparam int unsigned DEF_LEN_LSB    = 2 * DEF_TARGET_LENGTH;
    localparam int unsigned DEF_ID_LSB     = DEF_LEN_LSB + DEF_LEN_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2,
        ST_ISSUE   = 2'd3
    } packer_state_e;

endpackage

// File: rtl/sm_target_packer_if.sv
// Host base stream plus feeder load bus seen by the target packer.
//   s_valid/s_ready/s_base/s_last/s_id : host stream, one 2-bit base per beat
//   full                               : feeder full flag
//   ld/feed_out                        : one-cycle load strobe and packed word
// slave  = packer view, master = host/feeder view.
interface sm_target_packer_if #(
    parameter int unsigned ID_WIDTH  = 48,
    parameter int unsigned OUT_WIDTH = 316
) ();

    logic                 s_valid;
    logic                 s_ready;
    logic [1:0]           s_base;
    logic                 s_last;
    logic [ID_WIDTH-1:0]  s_id;
    logic                 full;
    logic                 ld;
    logic [OUT_WIDTH-1:0] feed_out;

    modport slave (
        input  s_valid, s_base, s_last, s_id, full,
        output s_ready, ld, feed_out
    );

    modport master (
        output s_valid, s_base, s_last, s_id, full,
        input  s_ready, ld, feed_out
    );

endinterface

// File: rtl/sm_target_packer.sv
// Packs a host stream of 2-bit bases into the feeder word {ID, LENGTH, TARGET}
// and loads it into the feeder with a one-cycle ld once the feeder is not full.
//   clk, rst        : clock, synchronous active-low reset
//   bus (slave)     : host stream in, feeder load out (see sm_target_packer_if)
//   o_err_overflow  : sticky, a sequence had more than TARGET_LENGTH bases
//   o_seq_count     : ld pulses issued since reset, wrapping
module sm_target_packer
    import sm_target_packer_pkg::*;
#(
    parameter int unsigned TARGET_LENGTH = DEF_TARGET_LENGTH,
    parameter int unsigned LEN_WIDTH     = DEF_LEN_WIDTH,
    parameter int unsigned ID_WIDTH      = DEF_ID_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    sm_target_packer_if.slave     bus,
    output logic                  o_err_overflow,
    output logic [15:0]           o_seq_count
);

    localparam int unsigned TGT_W = 2 * TARGET_LENGTH;
    localparam int unsigned SEQ_W = 16;

    packer_state_e          r_state;
    packer_state_e          w_state_nxt;
    logic                   r_ld;
    logic                   w_ld_nxt;
    logic                   w_ready_c;
    logic                   w_accept;
    logic [ID_WIDTH-1:0]    r_id;
    logic [LEN_WIDTH-1:0]   r_count;
    logic [TGT_W-1:0]       r_target;
    logic [TGT_W-1:0]       w_target_ins;
    logic                   r_err;
    logic [SEQ_W-1:0]       r_seq_count;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, ld strobe and stream handshake
    always_comb begin
        w_state_nxt = r_state;
        w_ld_nxt    = 1'b0;
        w_ready_c   = rst && ((r_state == ST_IDLE) || (r_state == ST_COLLECT));
        w_accept    = bus.s_valid && w_ready_c;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = bus.s_last ? ST_HOLD : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_accept && bus.s_last) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // full is only looked at here, while ld is low, so the
                // feeder's full->ld dependency cannot form a loop.
                if (!bus.full) begin
                    w_state_nxt = ST_ISSUE;
                    w_ld_nxt    = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Base insert decoder: base k lands in TARGET[2k+1:2k]
    always_comb begin
        w_target_ins = r_target;
        for (int unsigned k = 0; k < TARGET_LENGTH; k++) begin
            if (r_count == LEN_WIDTH'(k)) begin
                w_target_ins[2*k +: 2] = bus.s_base;
            end
        end
    end

    // Datapath: sequence assembly, overflow flag, load counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ld        <= 1'b0;
            r_id        <= '0;
            r_count     <= '0;
            r_target    <= '0;
            r_err       <= 1'b0;
            r_seq_count <= '0;
        end else begin
            r_ld <= w_ld_nxt;
            if (r_state == ST_ISSUE) begin
                r_seq_count <= r_seq_count + SEQ_W'(1);
            end
            if (w_accept) begin
                if (r_state == ST_IDLE) begin
                    r_id     <= bus.s_id;
                    r_target <= TGT_W'(bus.s_base);
                    r_count  <= LEN_WIDTH'(1);
                end else if (r_count < LEN_WIDTH'(TARGET_LENGTH)) begin
                    r_target <= w_target_ins;
                    r_count  <= r_count + LEN_WIDTH'(1);
                end else begin
                    // Excess beats are consumed and discarded
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.s_ready    = w_ready_c;
    assign bus.ld         = r_ld;
    assign bus.feed_out   = {r_id, r_count, r_target};
    assign o_err_overflow = r_err;
    assign o_seq_count    = r_seq_count;

endmodule

// File: tb/tb_sm_target_packer.sv
// Bench for sm_target_packer: randomized base streams checked against an
// array-based model of the feeder word {ID, LENGTH, TARGET}.
module tb_sm_target_packer;
    import sm_target_packer_pkg::*;

    localparam int unsigned TL = DEF_TARGET_LENGTH;
    localparam int unsigned LW = DEF_LEN_WIDTH;
    localparam int unsigned IW = DEF_ID_WIDTH;
    localparam int unsigned OW = DEF_OUT_WIDTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        err_overflow;
    logic [15:0] seq_count;

    sm_target_packer_if #(.ID_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    sm_target_packer dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .o_err_overflow (err_overflow),
        .o_seq_count    (seq_count)
    );

    always #5 clk = ~clk;

    int         n_vec   = 0;
    int         n_err   = 0;
    int         exp_seq = 0;
    logic [1:0] q_bases[$];

    // Expected feeder word from the collected base list
    function automatic logic [OW-1:0] model_word(input logic [IW-1:0] id);
        logic [2*TL-1:0] tgt;
        int              len;
        tgt = '0;
        len = (q_bases.size() > TL) ? int'(TL) : q_bases.size();
        for (int k = 0; k < len; k++) tgt[2*k +: 2] = q_bases[k];
        return {id, LW'(len), tgt};
    endfunction

    // Present one beat and hold it until it is accepted
    task automatic drive_beat(input logic [1:0] b, input logic last, input logic [IW-1:0] id);
        int guard;
        guard = 0;
        bus.s_valid = 1'b1;
        bus.s_base  = b;
        bus.s_last  = last;
        bus.s_id    = id;
        while (bus.s_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_vec++; n_err++;
            $display("FAIL beat_timeout: s_ready=%b required 1", bus.s_ready);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // Send a whole sequence; fixed < 0 selects random bases
    task automatic send_seq(input logic [IW-1:0] id, input int n, input int fixed, input bit gaps);
        logic [1:0] b;
        q_bases.delete();
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) @(negedge clk);
            b = (fixed < 0) ? 2'($urandom_range(0, 3)) : 2'(fixed);
            q_bases.push_back(b);
            drive_beat(b, (i == n - 1), id);
        end
    endtask

    // Wait up to max_wait cycles for ld, check the word and the pulse width
    task automatic expect_issue(input logic [OW-1:0] exp_word, input int max_wait, input string name);
        int w;
        w = 0;
        while (bus.ld !== 1'b1 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        n_vec++;
        if (bus.ld !== 1'b1) begin
            n_err++;
            $display("FAIL %s_ld: ld=%b after %0d cycles, required 1", name, bus.ld, w);
        end else begin
            n_vec++;
            if (bus.feed_out !== exp_word) begin
                n_err++;
                $display("FAIL %s_word: got %h required %h", name, bus.feed_out, exp_word);
            end
            exp_seq++;
            @(negedge clk);
            n_vec++;
            if (bus.ld !== 1'b0) begin
                n_err++;
                $display("FAIL %s_ld_width: ld=%b required 0", name, bus.ld);
            end
            n_vec++;
            if (seq_count !== 16'(exp_seq)) begin
                n_err++;
                $display("FAIL %s_seq_count: got %0d required %0d", name, seq_count, exp_seq);
            end
            n_vec++;
            if (bus.s_ready !== 1'b1) begin
                n_err++;
                $display("FAIL %s_ready_back: s_ready=%b required 1", name, bus.s_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.s_valid = 1'b0; bus.s_base = 2'd0; bus.s_last = 1'b0; bus.s_id = '0; bus.full = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.s_ready !== 1'b0 || bus.ld !== 1'b0 || bus.feed_out !== '0 ||
            err_overflow !== 1'b0 || seq_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_state: ready=%b ld=%b word=%h err=%b cnt=%0d required all 0",
                     bus.s_ready, bus.ld, bus.feed_out, err_overflow, seq_count);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b required 1", bus.s_ready);
        end
    endtask

    task automatic test_basic();
        logic [IW-1:0] id;
        logic [OW-1:0] exp;
        id = 48'hABCDEF012345;
        q_bases.delete();
        q_bases.push_back(2'd1); q_bases.push_back(2'd2);
        q_bases.push_back(2'd3); q_bases.push_back(2'd0);
        for (int i = 0; i < 4; i++) drive_beat(q_bases[i], (i == 3), id);
        exp = model_word(id);
        n_vec++;
        if (bus.ld !== 1'b0 || bus.s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_hold: ld=%b s_ready=%b required 0 0", bus.ld, bus.s_ready);
        end
        n_vec++;
        if (bus.feed_out[DEF_ID_LSB +: IW] !== id || bus.feed_out[DEF_LEN_LSB +: LW] !== LW'(4) ||
            bus.feed_out[7:0] !== 8'h39) begin
            n_err++;
            $display("FAIL basic_fields: got %h required %h", bus.feed_out, exp);
        end
        expect_issue(exp, 1, "basic");
    endtask

    task automatic test_full_backpressure();
        logic [IW-1:0] id;
        logic [OW-1:0] exp;
        id = 48'hABCDEF012345;
        bus.full = 1'b1;
        q_bases.delete();
        q_bases.push_back(2'd1); q_bases.push_back(2'd2);
        q_bases.push_back(2'd3); q_bases.push_back(2'd0);
        for (int i = 0; i < 4; i++) drive_beat(q_bases[i], (i == 3), id);
        exp = model_word(id);
        for (int c = 0; c < 10; c++) begin
            n_vec++;
            if (bus.ld !== 1'b0 || bus.s_ready !== 1'b0 || bus.feed_out !== exp) begin
                n_err++;
                $display("FAIL full_hold: cycle %0d ld=%b s_ready=%b word=%h", c, bus.ld, bus.s_ready, bus.feed_out);
            end
            @(negedge clk);
        end
        bus.full = 1'b0;
        expect_issue(exp, 1, "full_release");
    endtask

    task automatic test_overflow();
        logic [IW-1:0] id;
        logic [OW-1:0] exp;
        id = {16'h0, $urandom()};
        n_vec++;
        if (err_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_pre: err_overflow=%b required 0", err_overflow);
        end
        send_seq(id, 130, 3, 1'b0);
        exp = model_word(id);
        n_vec++;
        if (err_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_flag: err_overflow=%b required 1", err_overflow);
        end
        expect_issue(exp, 1, "ovf");
        id = {16'h0, $urandom()};
        send_seq(id, 9, -1, 1'b0);
        expect_issue(model_word(id), 1, "ovf_next");
        n_vec++;
        if (err_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: err_overflow=%b required 1", err_overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] id;
        id = 48'd5;
        q_bases.delete();
        q_bases.push_back(2'd2);
        drive_beat(2'd2, 1'b1, id);
        expect_issue(model_word(id), 1, "single");
        id = {$urandom(), 16'h0};
        send_seq(id, 3, 1, 1'b0);
        expect_issue(model_word(id), 1, "b2b_clean");
    endtask

    task automatic test_gaps();
        logic [IW-1:0] id;
        logic [OW-1:0] exp;
        for (int r = 0; r < 2; r++) begin
            id = {$urandom(), 16'($urandom())};
            send_seq(id, 37, -1, 1'b1);
            exp = model_word(id);
            n_vec++;
            if (bus.feed_out[DEF_LEN_LSB +: LW] !== LW'(37)) begin
                n_err++;
                $display("FAIL gaps_len: got %0d required 37", bus.feed_out[DEF_LEN_LSB +: LW]);
            end
            expect_issue(exp, 1, "gaps");
        end
    endtask

    task automatic test_mid_reset();
        logic [IW-1:0] id;
        id = 48'h123456789ABC;
        for (int i = 0; i < 5; i++) drive_beat(2'($urandom_range(0, 3)), 1'b0, id);
        rst = 1'b0;
        #1;
        n_vec++;
        if (bus.s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ready_forced: s_ready=%b required 0", bus.s_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_seq = 0;
        n_vec++;
        if (err_overflow !== 1'b0 || seq_count !== 16'd0 || bus.feed_out !== '0) begin
            n_err++;
            $display("FAIL rst_clear: err=%b cnt=%0d word=%h required 0", err_overflow, seq_count, bus.feed_out);
        end
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if (bus.ld !== 1'b0) begin
                n_err++;
                $display("FAIL rst_no_ld: cycle %0d ld=%b required 0", c, bus.ld);
            end
            @(negedge clk);
        end
        id = 48'h0000_0000_0777;
        send_seq(id, 3, -1, 1'b0);
        expect_issue(model_word(id), 1, "post_rst");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_full_backpressure();
        test_overflow();
        test_back_to_back();
        test_gaps();
        test_mid_reset();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
